// File: rtl/reg_bank_mp_pkg.sv
// Shared encodings for the multi-port register bank: write modes and clear-sequencer states.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    WR_BOTH = 2'b00,
    WR_LO   = 2'b01,
    WR_HI   = 2'b10,
    WR_SWAP = 2'b11
  } wr_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SWEEP = 2'b01,
    DONE  = 2'b10
  } clr_state_e;

endpackage

// File: rtl/reg_bank_mp_if.sv
// Control-unit facing bus of the register bank; master drives requests, slave is the bank.
interface reg_bank_mp_if #(
  parameter int DW   = 64,
  parameter int NREG = 16,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
);
  logic              regwen;
  logic [DW-1:0]     inA;
  logic [AW-1:0]     selwreg;
  logic [1:0]        endreg;
  logic [NRD*AW-1:0] selout;
  logic [NRD-1:0]    cnst;
  logic [DW-1:0]     kval;
  logic [NRD-1:0]    enrreg;
  logic [NRD*DW-1:0] out;
  logic              clr_req;
  logic              busy;
  logic              done;
  logic              wr_err;

  modport master (
    output regwen, inA, selwreg, endreg, selout, cnst, kval, enrreg, clr_req,
    input  out, busy, done, wr_err
  );

  modport slave (
    input  regwen, inA, selwreg, endreg, selout, cnst, kval, enrreg, clr_req,
    output out, busy, done, wr_err
  );
endinterface

// File: rtl/reg_bank_mp_clr_seq.sv
// Clear sequencer: walks every register index once, zeroing it, then pulses done.
module reg_bank_clr_seq
  import reg_bank_pkg::*;
#(
  parameter int NREG = 16,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr_req_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_idx_o
);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    clr_we_o  = 1'b0;
    clr_idx_o = idx_q;
    done_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        clr_we_o = 1'b1;
        if (idx_q == AW'(NREG - 1)) state_d = DONE;
        else                        idx_d   = idx_q + AW'(1);
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: rtl/reg_bank_mp.sv
// Multi-port register bank with half-word writes, swap, write-first bypass and a clear sweep.
module reg_bank_mp
  import reg_bank_pkg::*;
#(
  parameter int DW   = 64,
  parameter int NREG = 16,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic         clock,
  input  logic         reset,
  reg_bank_mp_if.slave bus
);

  localparam int HW = DW / 2;
  localparam logic [AW:0] NREG_W = (AW + 1)'(NREG);

  logic          busy, done, clr_we;
  logic [AW-1:0] clr_idx;
  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] wr_old, wr_d;
  logic          wr_ok, wr_err_q;

  function automatic logic idx_valid(input logic [AW-1:0] idx);
    return ({1'b0, idx} < NREG_W);
  endfunction

  function automatic logic [DW-1:0] merge_write(input logic [DW-1:0] old,
                                                input logic [DW-1:0] din,
                                                input wr_mode_e      mode);
    case (mode)
      WR_BOTH: return din;
      WR_LO:   return {old[DW-1:HW], din[HW-1:0]};
      WR_HI:   return {din[DW-1:HW], old[HW-1:0]};
      default: return {old[HW-1:0], old[DW-1:HW]};
    endcase
  endfunction

  reg_bank_clr_seq #(.NREG(NREG), .AW(AW)) u_clr_seq (
    .clock     (clock),
    .reset     (reset),
    .clr_req_i (bus.clr_req),
    .busy_o    (busy),
    .done_o    (done),
    .clr_we_o  (clr_we),
    .clr_idx_o (clr_idx)
  );

  // Loop-based lookup keeps out-of-range indices from touching the array.
  always_comb begin
    wr_ok  = bus.regwen && !busy && idx_valid(bus.selwreg);
    wr_old = '0;
    for (int r = 0; r < NREG; r++)
      if (bus.selwreg == AW'(r)) wr_old = regs_q[r];
    wr_d = merge_write(wr_old, bus.inA, wr_mode_e'(bus.endreg));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
      wr_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (clr_we && clr_idx == AW'(r))             regs_q[r] <= '0;
        else if (wr_ok && bus.selwreg == AW'(r))     regs_q[r] <= wr_d;
      end
      wr_err_q <= bus.regwen && (busy || !idx_valid(bus.selwreg));
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] sel;
    logic [DW-1:0] val, out_d, out_q;

    // Bypass only sees user writes; clear writes are never forwarded.
    always_comb begin
      sel = bus.selout[p*AW +: AW];
      val = '0;
      for (int r = 0; r < NREG; r++)
        if (sel == AW'(r)) val = regs_q[r];
      if (wr_ok && sel == bus.selwreg) val = wr_d;
      out_d = bus.cnst[p] ? bus.kval : val;
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset)             out_q <= '0;
      else if (bus.enrreg[p]) out_q <= out_d;
    end

    assign bus.out[p*DW +: DW] = out_q;
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.wr_err = wr_err_q;

endmodule

// File: tb/tb_reg_bank_mp.sv
// Bench for reg_bank_mp: directed steps plus a randomized phase against an array reference model.
module tb_reg_bank_mp;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  reg_bank_mp_if #(.DW(64), .NREG(16), .NRD(2)) i0 ();
  reg_bank_mp_if #(.DW(32), .NREG(8),  .NRD(3)) i1 ();
  reg_bank_mp_if #(.DW(32), .NREG(6),  .NRD(3)) i2 ();

  reg_bank_mp #(.DW(64), .NREG(16), .NRD(2)) d0 (.clock(clk), .reset(rst_n), .bus(i0));
  reg_bank_mp #(.DW(32), .NREG(8),  .NRD(3)) d1 (.clock(clk), .reset(rst_n), .bus(i1));
  reg_bank_mp #(.DW(32), .NREG(6),  .NRD(3)) d2 (.clock(clk), .reset(rst_n), .bus(i2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] mdl [16];
  logic [63:0] exp_out [2];

  function automatic logic [63:0] apply(input logic [63:0] old, input logic [63:0] din,
                                        input logic [1:0] mode);
    logic [31:0] olo, ohi;
    olo = old[31:0];
    ohi = old[63:32];
    case (mode)
      2'd0:    return din;
      2'd1:    return {ohi, din[31:0]};
      2'd2:    return {din[63:32], olo};
      default: return {olo, ohi};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input logic [63:0] d, input logic [1:0] m);
    i0.regwen  = 1'b1;
    i0.selwreg = 4'(idx);
    i0.inA     = d;
    i0.endreg  = m;
    tick();
    i0.regwen  = 1'b0;
    mdl[idx]   = apply(mdl[idx], d, m);
  endtask

  task automatic rd(input int a, input int b, input string tag);
    i0.selout = {4'(b), 4'(a)};
    i0.cnst   = 2'b00;
    i0.enrreg = 2'b11;
    tick();
    i0.enrreg = 2'b00;
    chk($sformatf("%s_p0_r%0d", tag, a), i0.out[63:0],   mdl[a]);
    chk($sformatf("%s_p1_r%0d", tag, b), i0.out[127:64], mdl[b]);
  endtask

  initial begin
    int cnt, dcyc, dn;
    logic        we;
    int          wi, s [2];
    logic [1:0]  wm, cn, en;
    logic [63:0] din, kv, post;

    rst_n = 1'b0;
    for (int r = 0; r < 16; r++) mdl[r] = '0;
    i0.regwen = 0; i0.inA = '0; i0.selwreg = '0; i0.endreg = '0; i0.selout = '0;
    i0.cnst = '0; i0.kval = '0; i0.enrreg = 2'b11; i0.clr_req = 0;
    i1.regwen = 0; i1.inA = '0; i1.selwreg = '0; i1.endreg = '0; i1.selout = '0;
    i1.cnst = '0; i1.kval = '0; i1.enrreg = '0; i1.clr_req = 0;
    i2.regwen = 0; i2.inA = '0; i2.selwreg = '0; i2.endreg = '0; i2.selout = '0;
    i2.cnst = '0; i2.kval = '0; i2.enrreg = '0; i2.clr_req = 0;

    // Reset state
    tick(); tick();
    chk("rst_out0", i0.out[63:0], 64'h0);
    chk("rst_out1", i0.out[127:64], 64'h0);
    chk("rst_busy", {63'h0, i0.busy}, 64'h0);
    chk("rst_done", {63'h0, i0.done}, 64'h0);
    chk("rst_wr_err", {63'h0, i0.wr_err}, 64'h0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_out0", i0.out[63:0], 64'h0);
    chk("post_rst_out1", i0.out[127:64], 64'h0);
    i0.enrreg = 2'b00;

    // Partial writes and swap
    wr(3, 64'h1111_2222_3333_4444, 2'b00);
    wr(3, 64'hAAAA_BBBB_CCCC_DDDD, 2'b01);
    rd(3, 0, "partial");
    chk("partial_abs", i0.out[63:0], 64'h1111_2222_CCCC_DDDD);
    wr(3, 64'h0, 2'b11);
    rd(0, 3, "swap");
    chk("swap_abs", i0.out[127:64], 64'hCCCC_DDDD_1111_2222);

    // Bypass with constant priority
    i0.regwen = 1; i0.selwreg = 4'd7; i0.inA = 64'h5; i0.endreg = 2'b00;
    i0.selout = {4'd7, 4'd7}; i0.cnst = 2'b10; i0.kval = 64'h9; i0.enrreg = 2'b11;
    tick();
    i0.regwen = 0; i0.cnst = 2'b00; i0.enrreg = 2'b00;
    mdl[7] = 64'h5;
    chk("bypass_out0", i0.out[63:0], 64'h5);
    chk("bypass_out1_cnst", i0.out[127:64], 64'h9);

    // Randomized traffic against the array model
    for (int c = 0; c < 300; c++) begin
      we  = 1'($urandom_range(0, 1));
      wi  = $urandom_range(0, 15);
      wm  = 2'($urandom_range(0, 3));
      din = {$urandom, $urandom};
      kv  = {$urandom, $urandom};
      for (int p = 0; p < 2; p++)
        s[p] = ($urandom_range(0, 3) == 0) ? wi : $urandom_range(0, 15);
      cn = 2'($urandom_range(0, 3));
      en = (c == 0) ? 2'b11 : 2'($urandom_range(0, 3));
      i0.regwen = we; i0.selwreg = 4'(wi); i0.endreg = wm; i0.inA = din;
      i0.selout = {4'(s[1]), 4'(s[0])}; i0.cnst = cn; i0.kval = kv; i0.enrreg = en;
      post = we ? apply(mdl[wi], din, wm) : mdl[wi];
      for (int p = 0; p < 2; p++)
        if (en[p]) exp_out[p] = cn[p] ? kv : ((we && s[p] == wi) ? post : mdl[s[p]]);
      mdl[wi] = post;
      tick();
      chk($sformatf("rand%0d_out0", c), i0.out[63:0], exp_out[0]);
      chk($sformatf("rand%0d_out1", c), i0.out[127:64], exp_out[1]);
      chk($sformatf("rand%0d_wr_err", c), {63'h0, i0.wr_err}, 64'h0);
    end
    i0.regwen = 0; i0.enrreg = 0; i0.cnst = 0;
    tick();

    // Clear sweep with a rejected write and an ignored clr_req
    for (int r = 0; r < 16; r++) wr(r, {32'hC0DE_0000 | 32'(r + 1), 32'(r * 7 + 1)}, 2'b00);
    i0.clr_req = 1;
    tick();
    i0.clr_req = 0;
    cnt = 0; dcyc = 0; dn = 0;
    while (i0.busy === 1'b1 && cnt < 40) begin
      cnt++;
      if (i0.done === 1'b1) begin dn++; dcyc = cnt; end
      if (cnt == 6) chk("sweep_wr_err", {63'h0, i0.wr_err}, 64'h1);
      if (cnt == 8) chk("sweep_wr_err_clears", {63'h0, i0.wr_err}, 64'h0);
      i0.regwen = (cnt == 5); i0.selwreg = 4'd1; i0.inA = '1; i0.endreg = 2'b00;
      i0.clr_req = (cnt == 10);
      tick();
    end
    i0.regwen = 0; i0.clr_req = 0;
    chk("sweep_busy_cycles", 64'(cnt), 64'd17);
    chk("sweep_done_cycle", 64'(dcyc), 64'd17);
    chk("sweep_done_count", 64'(dn), 64'd1);
    for (int r = 0; r < 16; r++) mdl[r] = '0;
    for (int r = 0; r < 16; r += 2) rd(r, r + 1, "after_sweep");

    // Async reset mid-sweep
    wr(15, 64'hFACE_FEED_0123_4567, 2'b00);
    wr(10, 64'h0BAD_F00D_DEAD_C0DE, 2'b00);
    rd(15, 10, "pre_abort");
    i0.clr_req = 1;
    tick();
    i0.clr_req = 0;
    tick(); tick(); tick(); tick();
    chk("abort_busy_before", {63'h0, i0.busy}, 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy_async", {63'h0, i0.busy}, 64'h0);
    chk("abort_out0_async", i0.out[63:0], 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int r = 0; r < 16; r++) mdl[r] = '0;
    rd(15, 10, "after_abort");
    rd(0, 5, "after_abort");
    chk("after_abort_busy", {63'h0, i0.busy}, 64'h0);

    // DW=32 NREG=8 NRD=3: high-half write read back on port 2
    i1.regwen = 1; i1.selwreg = 3'd5; i1.inA = 32'hDEAD_BEEF; i1.endreg = 2'b10;
    tick();
    i1.regwen = 0;
    chk("p8_wr_err", {63'h0, i1.wr_err}, 64'h0);
    i1.selout = {3'd5, 3'd0, 3'd0}; i1.enrreg = 3'b100;
    tick();
    i1.enrreg = 3'b000;
    chk("p8_r5_hi", {32'h0, i1.out[95:64]}, 64'hDEAD_0000);

    // NREG=6: out-of-range write is rejected and out-of-range read returns 0
    i2.regwen = 1; i2.selwreg = 3'd7; i2.inA = 32'h1234_5678; i2.endreg = 2'b00;
    tick();
    i2.regwen = 0;
    chk("p6_wr_err_pulse", {63'h0, i2.wr_err}, 64'h1);
    i2.selout = {3'd7, 3'd7, 3'd7}; i2.cnst = 3'b000; i2.enrreg = 3'b111;
    tick();
    chk("p6_wr_err_drop", {63'h0, i2.wr_err}, 64'h0);
    chk("p6_oor_read", {32'h0, i2.out[31:0]}, 64'h0);
    i2.regwen = 1; i2.selwreg = 3'd5; i2.inA = 32'hCAFE_0001; i2.endreg = 2'b00;
    i2.selout = {3'd5, 3'd7, 3'd0}; i2.enrreg = 3'b111;
    tick();
    i2.regwen = 0; i2.enrreg = 3'b000;
    chk("p6_bypass_r5", {32'h0, i2.out[95:64]}, 64'hCAFE_0001);
    chk("p6_wr_err_ok", {63'h0, i2.wr_err}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
